// File: rtl/uart_ins_loader.sv
// UART (8N1) program loader: packs received bytes big-endian into 32-bit words and
// writes them into instruction memory until a terminator word or full capacity.
module uart_ins_loader #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned AW       = 6,
    parameter int unsigned GAP_BITS = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          RXD,
    input  logic          START,
    output logic          WE,
    output logic [31:0]   W_Ins,
    output logic [AW-1:0] W_Addr,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERR,
    output logic [AW:0]   WCNT
);
    localparam int unsigned DIV = CLK_FREQ / BAUD;
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned GAP = GAP_BITS * DIV;
    localparam int unsigned GW  = $clog2(GAP + 1);

    localparam logic [CW-1:0] CntHalf = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] CntLast = CW'(DIV - 1);
    localparam logic [GW-1:0] GapLast = GW'(GAP - 1);
    localparam logic [AW:0]   WcntCap = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {RIdle, RStart, RData, RStop} rx_state_e;
    typedef enum logic {LIdle, LLoad} ld_state_e;

    // Two-flop synchronizer; resets to the idle-high line level.
    logic rx_meta_q, rxs_q;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= RXD;
            rxs_q     <= rx_meta_q;
        end
    end

    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_err_q, frame_err_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_state_q   <= RIdle;
            cnt_q        <= '0;
            bit_q        <= '0;
            sh_q         <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            sh_q         <= sh_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        rx_state_d   = rx_state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        sh_d         = sh_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        unique case (rx_state_q)
            RIdle: begin
                if (!rxs_q) begin
                    rx_state_d = RStart;
                    cnt_d      = '0;
                end
            end
            RStart: begin
                if (cnt_q == CntHalf) begin
                    cnt_d      = '0;
                    bit_d      = '0;
                    rx_state_d = rxs_q ? RIdle : RData;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RData: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    sh_d  = {rxs_q, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) rx_state_d = RStop;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RStop: begin
                if (cnt_q == CntLast) begin
                    cnt_d        = '0;
                    rx_state_d   = RIdle;
                    byte_valid_d = rxs_q;
                    frame_err_d  = !rxs_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: rx_state_d = RIdle;
        endcase
    end

    ld_state_e     ld_state_q, ld_state_d;
    logic [31:0]   word_q, word_d;
    logic [2:0]    nbyte_q, nbyte_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          we_q, we_d;
    logic [31:0]   w_ins_q, w_ins_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   wcnt_q, wcnt_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ld_state_q <= LIdle;
            word_q     <= '0;
            nbyte_q    <= '0;
            gap_q      <= '0;
            we_q       <= 1'b0;
            w_ins_q    <= '0;
            addr_q     <= '0;
            wcnt_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ld_state_q <= ld_state_d;
            word_q     <= word_d;
            nbyte_q    <= nbyte_d;
            gap_q      <= gap_d;
            we_q       <= we_d;
            w_ins_q    <= w_ins_d;
            addr_q     <= addr_d;
            wcnt_q     <= wcnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        ld_state_d = ld_state_q;
        word_d     = word_q;
        nbyte_d    = nbyte_q;
        gap_d      = gap_q;
        we_d       = 1'b0;
        w_ins_d    = w_ins_q;
        addr_d     = addr_q;
        wcnt_d     = wcnt_q;
        done_d     = done_q;
        err_d      = err_q;
        if (ld_state_q == LLoad) begin
            // Address/count advance the cycle after the write strobe.
            if (we_q) begin
                addr_d = addr_q + AW'(1);
                wcnt_d = wcnt_q + (AW + 1)'(1);
                if (wcnt_d == WcntCap) begin
                    done_d     = 1'b1;
                    ld_state_d = LIdle;
                end
            end
            if (nbyte_q == 3'd4) begin
                nbyte_d = '0;
                if (&word_q) begin
                    done_d     = 1'b1;
                    ld_state_d = LIdle;
                end else begin
                    we_d    = 1'b1;
                    w_ins_d = word_q;
                end
            end else if (frame_err_q) begin
                err_d   = 1'b1;
                nbyte_d = '0;
            end else if (byte_valid_q) begin
                word_d  = {word_q[23:0], sh_q};
                nbyte_d = nbyte_q + 3'd1;
                gap_d   = '0;
            end else if (nbyte_q != 3'd0) begin
                if (gap_q == GapLast) begin
                    err_d   = 1'b1;
                    nbyte_d = '0;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
        end
        // START arms from idle and restarts an active load alike.
        if (START) begin
            ld_state_d = LLoad;
            done_d     = 1'b0;
            err_d      = 1'b0;
            wcnt_d     = '0;
            addr_d     = '0;
            nbyte_d    = '0;
            gap_d      = '0;
            we_d       = 1'b0;
        end
    end

    assign WE     = we_q;
    assign W_Ins  = w_ins_q;
    assign W_Addr = addr_q;
    assign BUSY   = (ld_state_q == LLoad);
    assign DONE   = done_q;
    assign ERR    = err_q;
    assign WCNT   = wcnt_q;
endmodule

// File: tb/tb_uart_ins_loader.sv
// Randomized/directed bench for uart_ins_loader; expected writes come from a word-list model.
module tb_uart_ins_loader;
    localparam int AW  = 6;
    localparam int DIV = 10;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          RXD = 1'b1;
    logic          START = 1'b0;
    logic          WE;
    logic [31:0]   W_Ins;
    logic [AW-1:0] W_Addr;
    logic          BUSY, DONE, ERR;
    logic [AW:0]   WCNT;

    uart_ins_loader #(
        .CLK_FREQ(1000000),
        .BAUD    (100000),
        .AW      (AW),
        .GAP_BITS(32)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .RXD   (RXD),
        .START (START),
        .WE    (WE),
        .W_Ins (W_Ins),
        .W_Addr(W_Addr),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .ERR   (ERR),
        .WCNT  (WCNT)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int fails   = 0;

    logic [63:0] cap[$];
    logic [63:0] exp_q[$];
    logic [31:0] wq[$];
    logic        exp_done;
    int          exp_wcnt;

    always @(negedge CLK) if (WE === 1'b1) cap.push_back({32'(W_Addr), W_Ins});

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge CLK);
        RXD = 1'b0;
        cycles(DIV);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            cycles(DIV);
        end
        RXD = stop;
        cycles(DIV);
        RXD = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24], 1'b1);
        send_byte(w[23:16], 1'b1);
        send_byte(w[15:8], 1'b1);
        send_byte(w[7:0], 1'b1);
    endtask

    // Reference: words in order until terminator or capacity, addresses counting from 0.
    task automatic model_load();
        int n = 0;
        exp_q.delete();
        exp_done = 1'b0;
        foreach (wq[i]) begin
            if (wq[i] == 32'hFFFF_FFFF) begin
                exp_done = 1'b1;
                break;
            end
            exp_q.push_back({32'(n % (1 << AW)), wq[i]});
            n++;
            if (n == (1 << AW)) begin
                exp_done = 1'b1;
                break;
            end
        end
        exp_wcnt = n;
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_nwr"}, 64'(cap.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) chk(tag, cap[i], exp_q[i]);
    endtask

    task automatic send_wq();
        foreach (wq[i]) send_word(wq[i]);
        cycles(10);
    endtask

    initial begin
        logic [31:0] w;
        int n;

        // Reset with START toggling: everything stays at zero.
        cycles(3);
        START = 1'b1;
        cycles(2);
        START = 1'b0;
        cycles(2);
        chk("reset_outs", {31'd0, WE, W_Ins, W_Addr, BUSY, DONE, ERR, WCNT}, 64'd0);
        chk("reset_nwr", 64'(cap.size()), 64'd0);
        RST = 1'b1;
        cycles(20);
        chk("post_reset_busy", {63'd0, BUSY}, 64'd0);

        // Directed program with terminator.
        pulse_start();
        chk("armed_busy", {63'd0, BUSY}, 64'd1);
        cap.delete();
        wq = '{32'h2008_0005, 32'h2409_0007, 32'hFFFF_FFFF};
        send_wq();
        exp_q = '{{32'd0, 32'h2008_0005}, {32'd1, 32'h2409_0007}};
        check_writes("prog");
        chk("prog_flags", {60'd0, DONE, BUSY, ERR}, {60'd0, 1'b1, 1'b0, 1'b0});
        chk("prog_wcnt", 64'(WCNT), 64'd2);

        // Randomized programs against the model.
        for (int t = 0; t < 3; t++) begin
            pulse_start();
            cap.delete();
            wq.delete();
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                w = $urandom;
                if (w == 32'hFFFF_FFFF) w = 32'h0;
                wq.push_back(w);
            end
            wq.push_back(32'hFFFF_FFFF);
            model_load();
            send_wq();
            check_writes("rand");
            chk("rand_done", {63'd0, DONE}, {63'd0, exp_done});
            chk("rand_wcnt", 64'(WCNT), 64'(exp_wcnt));
            chk("rand_err", {63'd0, ERR}, 64'd0);
        end

        // Framing error in the 3rd byte.
        pulse_start();
        cap.delete();
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b0);
        cycles(30);
        chk("ferr_err", {63'd0, ERR}, 64'd1);
        chk("ferr_nwr", 64'(cap.size()), 64'd0);
        wq = '{32'h1122_3344};
        send_wq();
        exp_q = '{{32'd0, 32'h1122_3344}};
        check_writes("ferr_after");
        chk("ferr_sticky", {63'd0, ERR}, 64'd1);

        // Inter-byte timeout.
        pulse_start();
        cap.delete();
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        cycles(330 * DIV);
        chk("tmo_err", {63'd0, ERR}, 64'd1);
        chk("tmo_nwr", 64'(cap.size()), 64'd0);
        wq = '{32'hAABB_CCDD};
        send_wq();
        exp_q = '{{32'd0, 32'hAABB_CCDD}};
        check_writes("tmo_after");

        // Capacity: 64 random words, then a 65th that must be ignored.
        pulse_start();
        cap.delete();
        wq.delete();
        for (int i = 0; i < 65; i++) begin
            w = $urandom;
            if (w == 32'hFFFF_FFFF) w = 32'h1234_5678;
            wq.push_back(w);
        end
        model_load();
        send_wq();
        check_writes("cap");
        chk("cap_done", {63'd0, DONE}, {63'd0, exp_done});
        chk("cap_wcnt", 64'(WCNT), 64'(exp_wcnt));
        chk("cap_busy", {63'd0, BUSY}, 64'd0);

        // Glitch, then restart mid-word.
        pulse_start();
        cap.delete();
        RXD = 1'b0;
        cycles(3);
        RXD = 1'b1;
        cycles(30);
        chk("glitch_err", {63'd0, ERR}, 64'd0);
        chk("glitch_nwr", 64'(cap.size()), 64'd0);
        send_word(32'h0102_0304);
        cycles(10);
        chk("pre_restart_wcnt", 64'(WCNT), 64'd1);
        send_byte(8'h99, 1'b1);
        send_byte(8'h88, 1'b1);
        pulse_start();
        chk("restart_wcnt", 64'(WCNT), 64'd0);
        chk("restart_addr", 64'(W_Addr), 64'd0);
        cap.delete();
        wq = '{32'h5A6B_7C8D};
        send_wq();
        exp_q = '{{32'd0, 32'h5A6B_7C8D}};
        check_writes("restart");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/uart_ins_loader.md
Name: uart_ins_loader

Overview:
- Upstream feeder for the board-level MIPS top. It receives a program over a UART line (8N1), packs each group of 4 bytes into a 32-bit instruction, and writes it into the core's instruction memory through the existing WE/W_Ins write path.
- Loading starts on request. It ends on a terminator word or when memory is full, and it reports progress and errors for LED/7-seg display.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, UART bit rate; bit period DIV = CLK_FREQ/BAUD (integer division, DIV >= 4)
AW, 6, instruction address width; capacity 2**AW words
GAP_BITS, 32, inter-byte timeout in bit periods, applied within a partial word

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous reset, active low
RXD  input  1  UART serial input, idle high, asynchronous to CLK
START  input  1  single-cycle pulse from the debounced key; arms a new load
WE  output  1  instruction write strobe, one cycle per word
W_Ins  output  32  instruction word; valid whenever WE=1, held until the next write
W_Addr  output  AW  word address of the current write
BUSY  output  1  1 while armed/loading
DONE  output  1  sticky; load completed normally
ERR  output  1  sticky; framing error or timeout seen during this load
WCNT  output  AW+1  number of words written in this load

Behaviour:
- Reset (RST=0, async): all outputs 0. Receiver in R_IDLE, loader in L_IDLE, byte count 0. Reset mid-load aborts with no further writes.
- RXD passes through a 2-flop synchronizer. All logic uses the synchronized value rxs.
- Receiver FSM, uses bit counter cnt (0..DIV-1):
  - R_IDLE: on rxs=0, go to R_START and load cnt.
  - R_START: at DIV/2 cycles, sample. If rxs=1, treat as a glitch and return to R_IDLE with no error. Otherwise go to R_DATA.
  - R_DATA: sample 8 bits, each DIV cycles apart, LSB first.
  - R_STOP: sample after DIV cycles. rxs=1 raises byte_valid for 1 cycle. rxs=0 is a framing error: byte discarded, ERR set, partial word cleared. Then return to R_IDLE.
- Loader FSM:
  - L_IDLE: BUSY=0. START moves to L_LOAD and clears DONE, ERR, WCNT, W_Addr and the byte count. Bytes received in L_IDLE are discarded.
  - L_LOAD: BUSY=1. Each valid byte shifts into the word big-endian, so byte 0 lands in [31:24] and byte 3 in [7:0].
  - On the 4th byte, the next cycle handles the completed word:
    - If the word is 0xFFFFFFFF (terminator): no write; DONE=1; go to L_IDLE.
    - Otherwise: WE=1 for exactly one cycle with W_Ins = word and W_Addr = current address. On the following cycle W_Addr and WCNT increment.
    - If WCNT reaches 2**AW: DONE=1 and go to L_IDLE. A terminator is not required in this case.
- Latency: WE asserts 2 cycles after the stop-bit sample of the 4th byte.
- Timeout: while the byte count is 1..3, if no byte arrives within GAP_BITS*DIV cycles of the previous byte_valid, the partial word is discarded, ERR=1, the byte count returns to 0, and loading continues.
- START received while in L_LOAD restarts the load: counters and flags are cleared, and an in-flight partial word is dropped.
- A reception in progress at START or at DONE completes normally in the receiver. The loader then treats that byte per its current state.

Test Plan (CLK_FREQ=1000000, BAUD=100000, so DIV=10; AW=6):
- Reset: hold RST=0 with RXD=1 and toggle START → all outputs 0 and no WE. Release RST; no activity until START.
- START, then send bytes 20 08 00 05 24 09 00 07 FF FF FF FF → WE pulses twice:
  - W_Addr=0, W_Ins=0x20080005
  - W_Addr=1, W_Ins=0x24090007
  - then DONE=1, WCNT=2, BUSY=0, ERR=0.
- Framing error: in the 3rd byte, drive the stop bit low → ERR=1 and no WE. The next 4 good bytes 11 22 33 44 write 0x11223344 at W_Addr=0.
- Timeout: send 2 bytes, then idle 330 bit periods → ERR=1 and no WE. Following bytes AA BB CC DD write 0xAABBCCDD at address 0.
- Capacity: send 64 non-terminator words → 64 WE pulses at addresses 0..63, then DONE=1 and WCNT=64. A 65th word produces no WE.
- Glitch/restart: a 3-cycle low pulse on RXD gives no byte and no ERR. START mid-word clears WCNT; the next 4 bytes write at address 0.
